// File: rtl/clk_divider_pkg.sv
// Shared widths and divisor helpers for the clk_divider front end.
// Both divider paths import this package so their widths always match.
package clk_divider_pkg;

  localparam int DIV_W = 12;
  localparam int PWM_W = 5;

  // Odd paths always get LSB=1 and even paths LSB=0, whatever the port carries.
  function automatic logic [DIV_W-1:0] force_lsb(input logic [DIV_W-1:0] d,
                                                 input logic             odd);
    logic [DIV_W-1:0] r;
    if (odd) r = d | DIV_W'(1);
    else     r = d & ~DIV_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// One 50%-duty divider path: period counter, divisor capture at period start,
// high-phase decode, optional half-cycle negedge stage and rising-edge counter.
module clk_div_core
  import clk_divider_pkg::*;
#(
  parameter bit ODD_MODE = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             clk_div,
  output logic [PWM_W-1:0] pwm_cnt
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] n_act;
  logic [DIV_W-1:0] n_use;
  logic [DIV_W-1:0] half;
  logic             valid;
  logic             qp;
  logic             qp_next;
  logic             qn;

  // The port is only looked at when cnt==0, so a divisor change lands at the
  // next period boundary; invalid ratios keep cnt parked at 0 and re-sample.
  always_comb begin
    n_use    = (cnt == '0) ? force_lsb(div, ODD_MODE) : n_act;
    valid    = (n_use >= DIV_W'(2));
    half     = n_use >> 1;
    cnt_next = '0;
    if (valid && (cnt != n_use - DIV_W'(1))) cnt_next = cnt + DIV_W'(1);
    qp_next  = valid && (cnt_next != '0) && (cnt_next <= half);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      n_act   <= '0;
      qp      <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      cnt   <= cnt_next;
      n_act <= n_use;
      qp    <= qp_next;
      if (qp_next && !qp) pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // Odd ratios stretch the high phase by half a cycle via a negedge copy of qp.
  generate
    if (ODD_MODE) begin : g_odd
      always_ff @(negedge clk_in or posedge rst) begin
        if (rst) qn <= 1'b0;
        else     qn <= qp;
      end
    end else begin : g_even
      assign qn = 1'b0;
    end
  endgenerate

  assign clk_div = qp | qn;

endmodule

// File: rtl/clk_divider.sv
// Odd- and even-ratio 50%-duty clock dividers sharing clk_in, each with a
// rising-edge counter that serves as a PWM timebase.
module clk_divider
  import clk_divider_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_divider_odd,
  input  logic [DIV_W-1:0] clk_divider_even,
  output logic             Clk_Odd,
  output logic             Clk_Even,
  output logic [PWM_W-1:0] pwm_clk_odd,
  output logic [PWM_W-1:0] pwm_clk_even
);

  clk_div_core #(.ODD_MODE(1'b1)) u_odd (
    .clk_in  (clk_in),
    .rst     (rst),
    .div     (clk_divider_odd),
    .clk_div (Clk_Odd),
    .pwm_cnt (pwm_clk_odd)
  );

  clk_div_core #(.ODD_MODE(1'b0)) u_even (
    .clk_in  (clk_in),
    .rst     (rst),
    .div     (clk_divider_even),
    .clk_div (Clk_Even),
    .pwm_cnt (pwm_clk_even)
  );

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: half-cycle waveform model feeding an expected queue,
// a divisor table measured in time, and hand sequences for the corner cases.
module tb_clk_divider;
  import clk_divider_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic [DIV_W-1:0] div_odd;
  logic [DIV_W-1:0] div_even;
  logic             Clk_Odd;
  logic             Clk_Even;
  logic [PWM_W-1:0] pwm_clk_odd;
  logic [PWM_W-1:0] pwm_clk_even;

  int checks   = 0;
  int failures = 0;

  clk_divider dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .clk_divider_odd  (div_odd),
    .clk_divider_even (div_even),
    .Clk_Odd          (Clk_Odd),
    .Clk_Even         (Clk_Even),
    .pwm_clk_odd      (pwm_clk_odd),
    .pwm_clk_even     (pwm_clk_even)
  );

  // ---------------- clock ----------------
  always #10 clk_in = ~clk_in;

  // ---------------- check helper ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- waveform model + scoreboard ----------------
  // nxt counts half-cycles from the start of a period; output high while nxt < N.
  int o_nxt = 0, o_n = 0, o_pwm = 0;
  int e_nxt = 0, e_n = 0, e_pwm = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp, mon_act;
  bit          mon_qo, mon_qe;

  function automatic void path_step(input bit pos, input int port_n, inout int nxt,
                                    inout int n, inout int pwm, output bit q);
    q = 1'b0;
    if (nxt == 0) begin
      if (!pos) return;
      n = port_n;
      if (n < 2) return;
      pwm = (pwm + 1) % 32;
    end
    q   = (nxt < n);
    nxt = (nxt + 1) % (2 * n);
  endfunction

  always @(posedge clk_in or negedge clk_in) begin
    if (rst) begin
      o_nxt = 0; o_n = 0; o_pwm = 0;
      e_nxt = 0; e_n = 0; e_pwm = 0;
      mon_qo = 1'b0; mon_qe = 1'b0;
    end else begin
      path_step(clk_in, int'(div_odd | 12'd1), o_nxt, o_n, o_pwm, mon_qo);
      path_step(clk_in, int'(div_even & 12'hFFE), e_nxt, e_n, e_pwm, mon_qe);
    end
    exp_q.push_back({mon_qo, mon_qe, o_pwm[4:0], e_pwm[4:0]});
    #1;
    mon_act = {Clk_Odd, Clk_Even, pwm_clk_odd, pwm_clk_even};
    mon_exp = exp_q.pop_front();
    checks++;
    if (mon_act !== mon_exp) begin
      failures++;
      $display("FAIL scoreboard t=%0t act={odd=%b even=%b po=%0d pe=%0d} exp={odd=%b even=%b po=%0d pe=%0d}",
               $time, mon_act[11], mon_act[10], mon_act[9:5], mon_act[4:0],
               mon_exp[11], mon_exp[10], mon_exp[9:5], mon_exp[4:0]);
    end
  end

  // ---------------- driver / measurement tasks ----------------
  task automatic at_safe_time();
    @(negedge clk_in);
    #5;
  endtask

  // Measures period and high time of one divided clock; -1 if it never toggles.
  task automatic measure(input bit sel_odd, output int period, output int high);
    logic prev, cur;
    time  r1, f1;
    int   st;
    period = -1; high = -1; st = 0; r1 = 0; f1 = 0;
    @(posedge clk_in or negedge clk_in);
    #2;
    prev = sel_odd ? Clk_Odd : Clk_Even;
    for (int i = 0; i < 2000 && st < 3; i++) begin
      @(posedge clk_in or negedge clk_in);
      #2;
      cur = sel_odd ? Clk_Odd : Clk_Even;
      if (st == 0 && !prev && cur) begin
        r1 = $time; st = 1;
      end else if (st == 1 && prev && !cur) begin
        f1 = $time; st = 2;
      end else if (st == 2 && !prev && cur) begin
        period = int'($time - r1); high = int'(f1 - r1); st = 3;
      end
      prev = cur;
    end
  endtask

  // ---------------- divisor table ----------------
  typedef struct {
    logic [DIV_W-1:0] odd_div;
    logic [DIV_W-1:0] even_div;
    int odd_per;
    int odd_high;
    int even_per;
    int even_high;
  } vec_t;

  vec_t vecs[4];

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int per, hi, pe_frozen;
    bit found;

    vecs[0] = '{12'd5, 12'd6, 100, 50, 120, 60};
    vecs[1] = '{12'd3, 12'd2, 60, 30, 40, 20};
    vecs[2] = '{12'd4, 12'd7, 100, 50, 120, 60};
    vecs[3] = '{12'd9, 12'd10, 180, 90, 200, 100};

    // Reset with undriven divisors.
    #5;
    check("reset_clk_odd", int'(Clk_Odd), 0);
    check("reset_clk_even", int'(Clk_Even), 0);
    check("reset_pwm_odd", int'(pwm_clk_odd), 0);
    check("reset_pwm_even", int'(pwm_clk_even), 0);
    #50;
    div_odd  = 12'd5;
    div_even = 12'd6;
    rst      = 1'b0;

    // Both outputs rise on the first posedge after release.
    @(posedge clk_in); #1;
    check("first_rise_odd", int'(Clk_Odd), 1);
    check("first_rise_even", int'(Clk_Even), 1);
    check("first_pwm_odd", int'(pwm_clk_odd), 1);
    check("first_pwm_even", int'(pwm_clk_even), 1);

    // 40 even periods: wrap past 31 back to 8.
    repeat (239) @(posedge clk_in);
    #1;
    check("pwm_even_wrap", int'(pwm_clk_even), 8);
    check("pwm_odd_wrap", int'(pwm_clk_odd), 16);

    // Odd 5 -> 3 mid-period.
    repeat (2) @(posedge clk_in);
    at_safe_time();
    div_odd = 12'd3;
    measure(1'b1, per, hi);
    check("odd3_period", per, 60);
    check("odd3_high", hi, 30);

    // Even divisor 0 holds output low and freezes the counter.
    at_safe_time();
    div_even = 12'd0;
    repeat (12) @(posedge clk_in);
    #1;
    pe_frozen = e_pwm % 32;
    repeat (20) @(posedge clk_in);
    #1;
    check("even0_out", int'(Clk_Even), 0);
    check("even0_pwm_frozen", int'(pwm_clk_even), pe_frozen);
    at_safe_time();
    div_even = 12'd4;
    measure(1'b0, per, hi);
    check("even4_period", per, 80);
    check("even4_high", hi, 40);

    // Async reset while both outputs are high.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk_in);
      #3;
      if (Clk_Odd === 1'b1 && Clk_Even === 1'b1) found = 1'b1;
    end
    check("rst_high_found", int'(found), 1);
    rst = 1'b1;
    #1;
    check("async_rst_clk_odd", int'(Clk_Odd), 0);
    check("async_rst_clk_even", int'(Clk_Even), 0);
    check("async_rst_pwm_odd", int'(pwm_clk_odd), 0);
    check("async_rst_pwm_even", int'(pwm_clk_even), 0);
    div_odd  = 12'd1;
    div_even = 12'd4;
    #40;
    rst = 1'b0;
    @(posedge clk_in); #1;
    check("restart_even_rise", int'(Clk_Even), 1);
    check("restart_odd1_low", int'(Clk_Odd), 0);
    repeat (10) @(posedge clk_in);
    #1;
    check("odd1_held_low", int'(Clk_Odd), 0);
    check("odd1_pwm_frozen", int'(pwm_clk_odd), 0);
    at_safe_time();
    div_odd = 12'd7;
    measure(1'b1, per, hi);
    check("odd7_period", per, 140);
    check("odd7_high", hi, 70);

    // Table of divisor pairs, each from a fresh reset.
    for (int v = 0; v < 4; v++) begin
      at_safe_time();
      rst      = 1'b1;
      div_odd  = vecs[v].odd_div;
      div_even = vecs[v].even_div;
      #30;
      rst = 1'b0;
      measure(1'b1, per, hi);
      check($sformatf("tbl%0d_odd_period", v), per, vecs[v].odd_per);
      check($sformatf("tbl%0d_odd_high", v), hi, vecs[v].odd_high);
      measure(1'b0, per, hi);
      check($sformatf("tbl%0d_even_period", v), per, vecs[v].even_per);
      check($sformatf("tbl%0d_even_high", v), hi, vecs[v].even_high);
    end

    repeat (4) @(posedge clk_in);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
